// File: rtl/mem_if_pkg.sv
// Shared definitions for the 32-bit word memory port: access sizes, controller states
// and the size-to-beat-count helper used by the controller, memory model and bench.
package mem_if_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned SIZE_W     = 2;
  localparam int unsigned BEAT_CNT_W = 4;
  localparam int unsigned BEATS_W    = 5;

  typedef enum logic [SIZE_W-1:0] {
    SZ_1  = 2'b00,
    SZ_4  = 2'b01,
    SZ_8  = 2'b10,
    SZ_16 = 2'b11
  } access_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XFER = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic [BEATS_W-1:0] size_to_beats(input access_size_e size);
    logic [BEATS_W-1:0] beats;
    case (size)
      SZ_1:    beats = BEATS_W'(1);
      SZ_4:    beats = BEATS_W'(4);
      SZ_8:    beats = BEATS_W'(8);
      default: beats = BEATS_W'(16);
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/mem_burst_ctrl.sv
// Initiator-side burst controller: sequences single/burst word accesses onto the memory
// port, one beat per cycle, returns read words and flags misalignment and busy-echo faults.
module mem_burst_ctrl
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic              mem_enable,
  output logic              mem_read_write,
  output logic [1:0]        mem_access_size,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_busy
);

  state_e                  state_q, state_d;
  logic [BEAT_CNT_W-1:0]   beat_q, beat_d;
  access_size_e            size_q, size_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    rw_q, rw_d;
  logic                    en_q, en_d;
  logic                    pop_q, pop_d;
  logic                    rv_q, rv_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    ready_q, ready_d;
  logic                    busy_chk_q, busy_chk_d;
  logic [BEAT_CNT_W-1:0]   last_beat_c;

  assign last_beat_c = BEAT_CNT_W'(size_to_beats(size_q) - BEATS_W'(1));

  // Next-state and registered-output logic; every beat is decided one cycle ahead.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    size_d     = size_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    en_d       = 1'b0;
    pop_d      = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    rv_d       = en_q & rw_q;
    busy_chk_d = en_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          size_d = access_size_e'(req_size);
          rw_d   = ~req_write;
          addr_d = req_addr;
          beat_d = '0;
          err_d  = 1'b0;
          if (req_addr[1:0] == 2'b00) begin
            state_d = XFER;
            en_d    = 1'b1;
            pop_d   = req_write;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      XFER: begin
        if (beat_q == last_beat_c) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          beat_d = beat_q + BEAT_CNT_W'(1);
          addr_d = addr_q + ADDR_W'(WORD_BYTES);
          en_d   = 1'b1;
          pop_d  = ~rw_q;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The memory must echo busy the cycle after every enabled beat.
    if (busy_chk_q && !mem_busy) begin
      err_d = 1'b1;
    end

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      size_q     <= SZ_1;
      addr_q     <= '0;
      rw_q       <= 1'b1;
      en_q       <= 1'b0;
      pop_q      <= 1'b0;
      rv_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
      busy_chk_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      en_q       <= en_d;
      pop_q      <= pop_d;
      rv_q       <= rv_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      busy_chk_q <= busy_chk_d;
    end
  end

  // Write data and read data pass straight through within the beat / return cycle.
  assign mem_data_in     = pop_q ? wr_data : '0;
  assign rd_data         = mem_data_out;

  assign req_ready       = ready_q;
  assign wr_pop          = pop_q;
  assign rd_valid        = rv_q;
  assign done            = done_q;
  assign err             = err_q;
  assign mem_enable      = en_q;
  assign mem_read_write  = rw_q;
  assign mem_access_size = size_q;
  assign mem_address     = addr_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl with a registered word-memory model and a
// scoreboard of expected beat addresses and read words.
module tb_mem_burst_ctrl;
  import mem_if_pkg::*;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int          MAXC = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_write;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic          wr_pop, rd_valid, done, err;
  logic          mem_enable, mem_read_write;
  logic [1:0]    mem_access_size;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic          mem_busy;
  logic          busy_fault;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_rd[$];
  logic [31:0] wr_words[16];
  logic [31:0] ref_mem[256];
  bit          ref_wr[256];

  logic        cap_en[MAXC+1], cap_rw[MAXC+1], cap_pop[MAXC+1], cap_rv[MAXC+1];
  logic        cap_done[MAXC+1], cap_err[MAXC+1], cap_ready[MAXC+1];
  logic [31:0] cap_addr[MAXC+1], cap_rd[MAXC+1];
  logic [1:0]  cap_size[MAXC+1];

  always #5 clk = ~clk;

  mem_burst_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr),
    .wr_data(wr_data), .wr_pop(wr_pop),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .mem_enable(mem_enable), .mem_read_write(mem_read_write),
    .mem_access_size(mem_access_size), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_busy(mem_busy)
  );

  function automatic logic [31:0] init_word(input logic [7:0] idx);
    return (idx == 8'h40) ? 32'hDEAD_BEEF : {24'hC0FFEE, idx};
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [7:0] idx;
    idx = a[9:2];
    return ref_wr[idx] ? ref_mem[idx] : init_word(idx);
  endfunction

  // Registered memory: read data and busy echo appear the cycle after an enabled beat.
  logic [31:0] mem_store[256];
  bit          mem_wr[256];
  always @(posedge clk) begin
    if (mem_enable) begin
      if (mem_read_write)
        mem_data_out <= mem_wr[mem_address[9:2]] ? mem_store[mem_address[9:2]]
                                                 : init_word(mem_address[9:2]);
      else begin
        mem_store[mem_address[9:2]] <= mem_data_in;
        mem_wr[mem_address[9:2]]    <= 1'b1;
      end
    end
    mem_busy <= mem_enable & ~busy_fault;
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL accept_wait addr=%h: req_ready got=0 want=1 within 50 cycles", a);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = ~w; req_size = ~sz; req_addr = 32'h5555_5557;
  endtask

  task automatic capture(input int n);
    int p;
    p = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (wr_pop && p < 16) begin
        wr_data = wr_words[p];
        p++;
      end else begin
        wr_data = 32'h0BAD_0BAD;
      end
      cap_en[i] = mem_enable;    cap_rw[i] = mem_read_write; cap_pop[i] = wr_pop;
      cap_rv[i] = rd_valid;      cap_done[i] = done;         cap_err[i] = err;
      cap_ready[i] = req_ready;  cap_addr[i] = mem_address;  cap_rd[i] = rd_data;
      cap_size[i] = mem_access_size;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_addr = '0; wr_data = '0; busy_fault = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({mem_enable, wr_pop, rd_valid, done, err, mem_read_write, mem_access_size} !== 8'b0000_0100) begin
      bad++;
      $display("FAIL reset_ctrl en/pop/rv/done/err/rw/size got=%b want=00000100",
               {mem_enable, wr_pop, rd_valid, done, err, mem_read_write, mem_access_size});
    end
    total++;
    if (mem_address !== 32'h0) begin
      bad++;
      $display("FAIL reset_addr got=%h want=00000000", mem_address);
    end
    total++;
    if (mem_data_in !== 32'h0) begin
      bad++;
      $display("FAIL reset_data_in got=%h want=00000000", mem_data_in);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b want=1", req_ready);
    end
  endtask

  // One burst, checked cycle by cycle from T+1 to T+N+3 against the scoreboard.
  task automatic test_burst(input string name, input logic w, input logic [1:0] sz,
                            input logic [31:0] a, input logic fault);
    int nb;
    logic [31:0] ea;
    logic exp_en, exp_pop, exp_rv, exp_done, exp_err, exp_rdy;
    nb = int'(size_to_beats(access_size_e'(sz)));
    for (int k = 0; k < nb; k++) begin
      ea = a + 32'(k * 4);
      exp_addr.push_back(ea);
      if (w) begin
        ref_mem[ea[9:2]] = wr_words[k];
        ref_wr[ea[9:2]]  = 1'b1;
      end else begin
        exp_rd.push_back(ref_word(ea));
      end
    end
    busy_fault = fault;
    issue(w, sz, a);
    capture(nb + 3);
    busy_fault = 1'b0;
    for (int i = 1; i <= nb + 3; i++) begin
      exp_en   = (i <= nb);
      exp_pop  = w && (i <= nb);
      exp_rv   = !w && (i >= 2) && (i <= nb + 1);
      exp_done = (i == nb + 1);
      exp_err  = (i >= 3) && fault;
      exp_rdy  = (i >= nb + 2);
      total++;
      if ({cap_en[i], cap_pop[i], cap_rv[i], cap_done[i], cap_err[i], cap_ready[i]} !==
          {exp_en, exp_pop, exp_rv, exp_done, exp_err, exp_rdy}) begin
        bad++;
        $display("FAIL %s cyc%0d en/pop/rv/done/err/ready got=%b want=%b", name, i,
                 {cap_en[i], cap_pop[i], cap_rv[i], cap_done[i], cap_err[i], cap_ready[i]},
                 {exp_en, exp_pop, exp_rv, exp_done, exp_err, exp_rdy});
      end
      if (cap_en[i] === 1'b1 && exp_addr.size() > 0) begin
        ea = exp_addr.pop_front();
        total++;
        if (cap_addr[i] !== ea || cap_rw[i] !== ~w || cap_size[i] !== sz) begin
          bad++;
          $display("FAIL %s cyc%0d addr/rw/size got=%h/%b/%b want=%h/%b/%b", name, i,
                   cap_addr[i], cap_rw[i], cap_size[i], ea, ~w, sz);
        end
      end
      if (cap_rv[i] === 1'b1 && exp_rd.size() > 0) begin
        ea = exp_rd.pop_front();
        total++;
        if (cap_rd[i] !== ea) begin
          bad++;
          $display("FAIL %s cyc%0d rd_data got=%h want=%h", name, i, cap_rd[i], ea);
        end
      end
    end
    total++;
    if (exp_addr.size() != 0 || exp_rd.size() != 0) begin
      bad++;
      $display("FAIL %s leftover beats/words got=%0d/%0d want=0/0", name,
               exp_addr.size(), exp_rd.size());
      exp_addr.delete();
      exp_rd.delete();
    end
  endtask

  task automatic test_misaligned;
    issue(1'b0, 2'b10, 32'h0000_0102);
    capture(3);
    for (int i = 1; i <= 3; i++) begin
      total++;
      if ({cap_en[i], cap_done[i], cap_err[i], cap_ready[i]} !==
          {1'b0, i == 1, 1'b1, i != 1}) begin
        bad++;
        $display("FAIL misaligned cyc%0d en/done/err/ready got=%b want=%b", i,
                 {cap_en[i], cap_done[i], cap_err[i], cap_ready[i]},
                 {1'b0, i == 1, 1'b1, i != 1});
      end
    end
    test_burst("after_misaligned", 1'b0, 2'b00, 32'h0000_0100, 1'b0);
  endtask

  task automatic test_reset_mid_burst;
    int seen;
    issue(1'b0, 2'b10, 32'h0000_0300);
    repeat (3) @(negedge clk);
    total++;
    if (mem_enable !== 1'b1 || mem_address !== 32'h0000_0308) begin
      bad++;
      $display("FAIL rst_mid beat2 en/addr got=%b/%h want=1/00000308", mem_enable, mem_address);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({mem_enable, rd_valid, done, wr_pop} !== 4'b0000) begin
      bad++;
      $display("FAIL rst_mid after_reset en/rv/done/pop got=%b want=0000",
               {mem_enable, rd_valid, done, wr_pop});
    end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || mem_enable) seen++;
    end
    total++;
    if (seen != 0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid abandon stray_cycles/ready got=%0d/%b want=0/1", seen, req_ready);
    end
    test_burst("after_reset", 1'b0, 2'b00, 32'h0000_0100, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_burst("single_read", 1'b0, 2'b00, 32'h0000_0100, 1'b0);
    wr_words[0] = 32'h11; wr_words[1] = 32'h22; wr_words[2] = 32'h33; wr_words[3] = 32'h44;
    test_burst("burst_write", 1'b1, 2'b01, 32'h0000_0200, 1'b0);
    test_burst("readback", 1'b0, 2'b01, 32'h0000_0200, 1'b0);
    test_burst("wrap_read", 1'b0, 2'b11, 32'hFFFF_FFF0, 1'b0);
    test_misaligned();
    test_reset_mid_burst();
    test_burst("busy_fault", 1'b0, 2'b01, 32'h0000_0200, 1'b1);
    test_burst("after_busy_fault", 1'b0, 2'b00, 32'h0000_0100, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_burst_ctrl.md
# mem_burst_ctrl

Initiator-side controller for the 32-bit word memory port. It accepts single or burst read/write requests from a pipeline client (fetch or load/store stage) and sequences them onto the memory's enable / read_write / access_size / address / data_in pins, one word per cycle. It returns read words to the client with a valid strobe and signals completion. It also checks the memory's busy echo.

## Interface
- ADDR_W, 32, byte-address width
- DATA_W, 32, word width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  client request present
- req_ready  out  1  controller can accept request (IDLE only)
- req_write  in  1  1 = write burst, 0 = read burst
- req_size  in  2  00 = 1 word, 01 = 4, 10 = 8, 11 = 16
- req_addr  in  ADDR_W  start byte address
- wr_data  in  DATA_W  write word for current beat
- wr_pop  out  1  wr_data consumed this cycle
- rd_data  out  DATA_W  read word (passthrough of mem_data_out)
- rd_valid  out  1  rd_data valid this cycle
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error flag, cleared on next accepted request
- mem_enable  out  1  memory enable
- mem_read_write  out  1  1 = read, 0 = write
- mem_access_size  out  2  latched req_size
- mem_address  out  ADDR_W  beat byte address
- mem_data_in  out  DATA_W  write data to memory
- mem_data_out  in  DATA_W  registered read data from memory
- mem_busy  in  1  memory busy echo

## Operation
- States: IDLE, XFER, DONE.
- IDLE:
  - req_ready = 1.
  - Accept on req_valid & req_ready.
  - Latch write, size, addr. Beat count N = 1/4/8/16. Clear err.
  - Aligned address (req_addr[1:0] == 0): go to XFER.
  - Misaligned address: set err, issue no beats, go to DONE.
- XFER, beat k = 0..N-1, one per cycle:
  - mem_enable = 1, mem_address = addr + 4k (modulo 2^ADDR_W, wraps silently).
  - mem_read_write = ~write; mem_access_size = latched size.
  - Write beats: mem_data_in = wr_data, wr_pop = 1.
  - After beat N-1, go to DONE.
- DONE:
  - done = 1 for one cycle, req_ready = 0, then IDLE.
- Reads: rd_valid is registered. It is high in the cycle after each read beat, with rd_data = mem_data_out. The last rd_valid coincides with done.
- Busy check: mem_busy must be 1 in the cycle after every enabled beat; otherwise set err. err does not abort the burst.
- req_* inputs are ignored outside IDLE. Client changes mid-burst have no effect.
- Reset values:
  - state IDLE
  - mem_enable, wr_pop, rd_valid, done, err = 0
  - mem_address, mem_data_in, mem_access_size = 0; mem_read_write = 1
  - req_ready = 1 once rst_n is released.

## Timing
- Accept in cycle T. Beat k is driven in cycle T+1+k. DONE occurs in cycle T+1+N.
- Read word k is valid in cycle T+2+k.
- Write word k is sampled in cycle T+1+k, with wr_pop high that cycle. The client must drive valid wr_data whenever wr_pop = 1.
- Misaligned request: no mem_enable; done and err are seen in cycle T+1.
- Back-to-back requests: the next accept is no earlier than T+N+2.
- rst_n low in any cycle: all outputs take reset values at the next edge. Any burst in progress is abandoned with no done pulse.
- No combinational path from req_valid to mem_* outputs.
- rd_data is combinational from mem_data_out.

## Structure
- Shared package mem_if_pkg:
  - access_size enum SZ_1 = 2'b00, SZ_4, SZ_8, SZ_16
  - function size_to_beats returning 1/4/8/16
  - constant WORD_BYTES = 4
  - state enum {IDLE, XFER, DONE}
- The same package is imported by the memory model and the testbench.
- Single module; a 4-bit beat counter and an address incrementer live inline. No sub-module.

## Test plan
- Single read: memory[0x100] = 0xDEADBEEF, req size 00 at addr 0x100, accept at T -> mem_enable at T+1 only, with address 0x100 and read_write = 1; rd_valid = 1 with rd_data 0xDEADBEEF at T+2; done at T+2; err = 0.
- Burst write: size 01 at 0x200, wr_data 0x11, 0x22, 0x33, 0x44 -> mem_enable T+1..T+4, addresses 0x200, 0x204, 0x208, 0x20C, read_write = 0, four wr_pop pulses; done at T+5. A size-01 readback returns the same four words.
- Wrap: size 11 read at 0xFFFFFFF0 -> addresses 0xFFFFFFF0..0xFFFFFFFC then 0x0..0x2C; 16 rd_valid pulses T+2..T+17; done at T+17.
- Misaligned: size 10 at 0x102 -> mem_enable never asserted; done and err = 1 at T+1; err clears when the next aligned request is accepted.
- Reset mid-burst: size 10 read, rst_n low during beat 2 -> next edge mem_enable = 0, rd_valid = 0, no done; after release req_ready = 1 and a new request completes normally.
- Busy fault: memory model holds mem_busy = 0 during a size-01 read -> err = 1 after the first beat; all 4 beats still issue; done at T+5.
